midi_note_tx: RTL

//   Inverse of the MIDI note lookup: takes a tiny-synth { note:4, octave:4 } pair plus

---
 rtl/midi_note_tx.sv | 101 ++++++++++
 1 files changed

// File: rtl/midi_note_tx.sv
// midi_note_tx: turns a {note,octave} pair, velocity and gate into a MIDI Note On/Off message on an 8N1 line.
// Define MIDI_TX_RUNNING_STATUS_EN to omit a status byte that repeats the previously sent one.
module midi_note_tx #(
    parameter int          CLK_FREQ = 16000000,
    parameter int          BAUD     = 31250,
    parameter logic [3:0]  CHANNEL  = 4'd0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] note_and_octave,
    input  logic [6:0] velocity,
    input  logic       gate,
    input  logic       valid,
    output logic       ready,
    output logic       serial_out,
    output logic       busy,
    output logic       err_range
);
    localparam int BIT_DIV = CLK_FREQ / BAUD;
    localparam int DW = BIT_DIV > 1 ? $clog2(BIT_DIV) : 1;
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
    state_t state_q, state_d;
    logic [DW-1:0] div_q, div_d;
    logic [2:0] bit_q, bit_d;
    logic [1:0] byte_q, byte_d;
    logic [7:0] st_q, num_q, vel_q, cur;
    logic err_q;
    logic [3:0] note, oct;
    logic [7:0] n, status;
    logic in_range, accept, tick, skip_b0;
    assign {note, oct} = note_and_octave;
    // 12*oct = 8*oct + 4*oct; max 195 still fits in 8 bits
    assign n = {1'b0, oct, 3'b000} + {2'b00, oct, 2'b00} + {4'b0000, note};
    assign in_range = (note < 4'd12) && !n[7];
    assign accept = valid && state_q == IDLE;
    assign tick = div_q == DW'(BIT_DIV - 1);
    assign status = {gate ? 4'h9 : 4'h8, CHANNEL};
`ifdef MIDI_TX_RUNNING_STATUS_EN
    logic [7:0] ls_q;
    logic ls_vld_q;
    assign skip_b0 = ls_vld_q && ls_q == status;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ls_q <= '0;
            ls_vld_q <= 1'b0;
        end else if (accept && in_range && !skip_b0) begin
            ls_q <= status;
            ls_vld_q <= 1'b1;
        end
    end
`else
    assign skip_b0 = 1'b0;
`endif
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else state_q <= state_d;
    end
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:  state_d = accept && in_range ? START : IDLE;
            START: state_d = tick ? DATA : START;
            DATA:  state_d = tick && bit_q == 3'd7 ? STOP : DATA;
            STOP:  state_d = tick ? (byte_q == 2'd2 ? IDLE : START) : STOP;
        endcase
    end
    always_comb begin
        div_d = state_q == IDLE || tick ? '0 : div_q + DW'(1);
        bit_d = state_q == DATA && tick ? bit_q + 3'd1 : bit_q;
        byte_d = accept ? (skip_b0 ? 2'd1 : 2'd0)
               : state_q == STOP && tick ? (byte_q == 2'd2 ? 2'd0 : byte_q + 2'd1) : byte_q;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_q <= '0;
            bit_q <= '0;
            byte_q <= '0;
            st_q <= '0;
            num_q <= '0;
            vel_q <= '0;
            err_q <= 1'b0;
        end else begin
            div_q <= div_d;
            bit_q <= bit_d;
            byte_q <= byte_d;
            err_q <= accept && !in_range;
            if (accept && in_range) begin
                st_q <= status;
                num_q <= {1'b0, n[6:0]};
                vel_q <= {1'b0, velocity};
            end
        end
    end
    always_comb begin
        cur = byte_q == 2'd0 ? st_q : byte_q == 2'd1 ? num_q : vel_q;
        serial_out = state_q == START ? 1'b0 : state_q == DATA ? cur[bit_q] : 1'b1;
        ready = state_q == IDLE;
        busy = state_q != IDLE;
        err_range = err_q;
    end
endmodule
